// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants: board clock, oversample default and per-baud divisors.
package uart_pkg;
    localparam int CLK_HZ = 50_000_000;
    localparam int OVS_DEF = 16;
    localparam int FRAC_W_DEF = 4;
    localparam int MIN_DIV = 2;
    localparam int DEF_BAUD = 19_200;

    function automatic int div_fixed(int baud, int ovs, int frac_w);
        longint num;
        longint den;
        num = longint'(CLK_HZ) <<< frac_w;
        den = longint'(ovs) * longint'(baud);
        return int'((num + den / 2) / den);
    endfunction

    localparam int DIV_9600_FX = div_fixed(9_600, OVS_DEF, FRAC_W_DEF);
    localparam int DIV_19200_FX = div_fixed(19_200, OVS_DEF, FRAC_W_DEF);
    localparam int DIV_115200_FX = div_fixed(115_200, OVS_DEF, FRAC_W_DEF);
    localparam int DIV_9600_INT = DIV_9600_FX >>> FRAC_W_DEF;
    localparam int DIV_9600_FRAC = DIV_9600_FX % (1 << FRAC_W_DEF);
    localparam int DIV_19200_INT = DIV_19200_FX >>> FRAC_W_DEF;
    localparam int DIV_19200_FRAC = DIV_19200_FX % (1 << FRAC_W_DEF);
    localparam int DIV_115200_INT = DIV_115200_FX >>> FRAC_W_DEF;
    localparam int DIV_115200_FRAC = DIV_115200_FX % (1 << FRAC_W_DEF);

    // Reset divisor is integer-only: the default baud rounded to whole cycles.
    localparam int DEF_DIV_BOARD = (CLK_HZ + OVS_DEF * DEF_BAUD / 2) / (OVS_DEF * DEF_BAUD);
    localparam int DEF_FRAC_BOARD = 0;
endpackage

// File: rtl/uart_frac_divider.sv
// uart_frac_divider: integer-plus-fraction clock divider emitting a one-cycle sample tick.
module uart_frac_divider
    import uart_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int FRAC_W = 4,
    parameter int DEF_DIV = DEF_DIV_BOARD,
    parameter int DEF_FRAC = DEF_FRAC_BOARD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              restart,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              sample_tck,
    output logic              load_pend
);
    logic [DIV_W-1:0] cnt, act_int, pend_int;
    logic [FRAC_W-1:0] acc, act_frac, pend_frac;
    logic extra;
    logic [DIV_W:0] period;

    function automatic logic [DIV_W-1:0] clamp(logic [DIV_W-1:0] v);
        return (v < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : v;
    endfunction

    assign period = {1'b0, act_int} + {{DIV_W{1'b0}}, extra};
    // >= rather than == so a direct load that shrinks the divisor below cnt cannot run cnt around its full range.
    assign sample_tck = en & ~restart & ({1'b0, cnt} + (DIV_W+1)'(1) >= period);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            acc <= '0;
            extra <= 1'b0;
            act_int <= clamp(DIV_W'(DEF_DIV));
            act_frac <= FRAC_W'(DEF_FRAC);
            pend_int <= DIV_W'(DEF_DIV);
            pend_frac <= FRAC_W'(DEF_FRAC);
            load_pend <= 1'b0;
        end else begin
            if (div_load) begin
                pend_int <= div_int;
                pend_frac <= div_frac;
            end
            if (restart) begin
                cnt <= '0;
                acc <= '0;
                extra <= 1'b0;
                load_pend <= 1'b0;
                if (div_load) begin
                    act_int <= clamp(div_int);
                    act_frac <= div_frac;
                end else if (load_pend) begin
                    act_int <= clamp(pend_int);
                    act_frac <= pend_frac;
                end
            end else if (sample_tck) begin
                cnt <= '0;
                {extra, acc} <= {1'b0, acc} + {1'b0, act_frac};
                load_pend <= div_load;
                if (load_pend) begin
                    act_int <= clamp(pend_int);
                    act_frac <= pend_frac;
                end
            end else if (div_load && !en) begin
                act_int <= clamp(div_int);
                act_frac <= div_frac;
                load_pend <= 1'b0;
            end else begin
                if (en) cnt <= cnt + DIV_W'(1);
                if (div_load) load_pend <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable baud generator producing oversample, mid-bit and end-of-bit ticks.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OVS = OVS_DEF,
    parameter int DEF_DIV = DEF_DIV_BOARD,
    parameter int DEF_FRAC = DEF_FRAC_BOARD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    restart,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    input  logic                    div_load,
    output logic                    sample_tck,
    output logic                    mid_tck,
    output logic                    bit_tck,
    output logic [$clog2(OVS)-1:0]  ovs_cnt,
    output logic                    load_pend
);
    localparam int OW = $clog2(OVS);
    logic [OW-1:0] ovs;

    uart_frac_divider #(
        .DIV_W(DIV_W),
        .FRAC_W(FRAC_W),
        .DEF_DIV(DEF_DIV),
        .DEF_FRAC(DEF_FRAC)
    ) u_div (
        .clk(clk),
        .reset(reset),
        .en(en),
        .restart(restart),
        .div_int(div_int),
        .div_frac(div_frac),
        .div_load(div_load),
        .sample_tck(sample_tck),
        .load_pend(load_pend)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovs <= '0;
        else if (restart) ovs <= '0;
        else if (sample_tck) ovs <= (ovs == OW'(OVS-1)) ? '0 : ovs + OW'(1);
    end

    assign mid_tck = sample_tck & (ovs == OW'(OVS/2-1));
    assign bit_tck = sample_tck & (ovs == OW'(OVS-1));
    assign ovs_cnt = ovs;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed and randomized checks of tick spacing against an arithmetic interval model.
module tb_uart_baud_gen;
    localparam int DIV_W = 16;
    localparam int FRAC_W = 4;
    localparam int OVS = 16;
    localparam int DEF_DIV = 163;
    localparam int FSCALE = 1 << FRAC_W;

    logic clk = 1'b0;
    logic reset, en, restart, div_load;
    logic [DIV_W-1:0] div_int;
    logic [FRAC_W-1:0] div_frac;
    logic sample_tck, mid_tck, bit_tck, load_pend;
    logic [$clog2(OVS)-1:0] ovs_cnt;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_baud_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEF_DIV(DEF_DIV), .DEF_FRAC(0)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .restart(restart),
        .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
        .sample_tck(sample_tck), .mid_tck(mid_tck), .bit_tck(bit_tck),
        .ovs_cnt(ovs_cnt), .load_pend(load_pend)
    );

    // Interval k after a restart: clamped integer part plus the carry produced by the k-th fraction add.
    function automatic int model_len(int d, int f, int k);
        int e;
        e = (d < 2) ? 2 : d;
        return (k == 0) ? e : e + (k * f) / FSCALE - ((k - 1) * f) / FSCALE;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic meas(input bit rnd, output int n, output int g);
        n = 0;
        g = 0;
        do begin
            next_cyc();
            restart = 1'b0;
            div_load = 1'b0;
            en = rnd ? ($urandom_range(7) != 0) : 1'b1;
            #1;
            n++;
            if (!en) g++;
        end while (!sample_tck && n < 3000);
    endtask

    task automatic load_direct(input int d, input int f);
        next_cyc();
        en = 1'b0;
        restart = 1'b0;
        div_int = DIV_W'(d);
        div_frac = FRAC_W'(f);
        div_load = 1'b1;
        #1;
    endtask

    task automatic do_restart();
        next_cyc();
        en = 1'b1;
        div_load = 1'b0;
        restart = 1'b1;
        #1;
    endtask

    initial begin
        int n, g, sum, d, f, first_mid, first_bit, second_bit, nsamp;
        reset = 1'b1;
        en = 1'b0;
        restart = 1'b0;
        div_load = 1'b0;
        div_int = '0;
        div_frac = '0;
        repeat (2) next_cyc();
        #1;
        chk("rst_sample", sample_tck, 0);
        chk("rst_mid", mid_tck, 0);
        chk("rst_bit", bit_tck, 0);
        chk("rst_ovs", ovs_cnt, 0);
        chk("rst_pend", load_pend, 0);
        next_cyc();
        reset = 1'b0;
        #1;

        do_restart();
        meas(0, n, g);
        chk("default_len", n, DEF_DIV);

        load_direct(4, 0);
        do_restart();
        chk("restart_no_tick", sample_tck, 0);
        first_mid = -1;
        first_bit = -1;
        second_bit = -1;
        nsamp = 0;
        for (int i = 1; i <= 128; i++) begin
            next_cyc();
            restart = 1'b0;
            #1;
            nsamp += int'(sample_tck);
            if (mid_tck && first_mid < 0) first_mid = i;
            if (bit_tck && first_bit >= 0 && second_bit < 0) second_bit = i;
            if (bit_tck && first_bit < 0) first_bit = i;
        end
        chk("first_mid", first_mid, 32);
        chk("first_bit", first_bit, 64);
        chk("second_bit", second_bit, 128);
        chk("samples_128", nsamp, 32);

        load_direct(4, 8);
        do_restart();
        sum = 0;
        for (int k = 0; k < 100; k++) begin
            meas(0, n, g);
            sum += n;
            chk($sformatf("frac8_len%0d", k), n, model_len(4, 8, k));
        end
        chk("frac8_sum_within1", int'(sum >= 449 && sum <= 451), 1);

        load_direct(4, 0);
        do_restart();
        meas(0, n, g);
        next_cyc();
        en = 1'b1;
        div_int = 10;
        div_frac = 0;
        div_load = 1'b1;
        #1;
        meas(0, n, g);
        chk("pend_old_len_rest", n, 3);
        chk("pend_high_at_tick", load_pend, 1);
        meas(0, n, g);
        chk("pend_new_len", n, 10);
        chk("pend_cleared", load_pend, 0);

        for (int i = 1; i <= 9; i++) begin
            next_cyc();
            en = (i <= 2);
            #1;
        end
        meas(0, n, g);
        chk("en_low_stretch", n + 9, 17);
        for (int i = 1; i <= 9; i++) begin
            next_cyc();
            en = (i <= 2);
            div_load = (i == 5);
            div_int = 6;
            #1;
            if (i == 6) chk("en_low_load_no_pend", load_pend, 0);
        end
        meas(0, n, g);
        chk("en_low_load_len", n + 9, 13);
        meas(0, n, g);
        chk("direct_load_len", n, 6);

        for (int i = 1; i <= 5; i++) begin
            next_cyc();
            #1;
        end
        next_cyc();
        restart = 1'b1;
        #1;
        chk("restart_at_due_no_tick", sample_tck, 0);
        next_cyc();
        restart = 1'b0;
        #1;
        chk("restart_ovs_zero", ovs_cnt, 0);
        meas(0, n, g);
        chk("restart_at_due_len", n + 1, 6);

        load_direct(0, 0);
        do_restart();
        meas(0, n, g);
        chk("div0_len", n, 2);
        meas(0, n, g);
        chk("div0_len2", n, 2);
        load_direct(1, 0);
        do_restart();
        meas(0, n, g);
        chk("div1_len", n, 2);

        next_cyc();
        restart = 1'b1;
        div_load = 1'b1;
        div_int = 7;
        div_frac = 0;
        #1;
        meas(0, n, g);
        chk("load_restart_len", n, 7);
        chk("load_restart_no_pend", load_pend, 0);

        div_int = 9;
        div_load = 1'b1;
        #1;
        chk("load_on_tick_tick", sample_tck, 1);
        meas(0, n, g);
        chk("load_on_tick_old_len", n, 7);
        chk("load_on_tick_pend", load_pend, 1);
        meas(0, n, g);
        chk("load_on_tick_new_len", n, 9);

        next_cyc();
        div_int = 50;
        div_load = 1'b1;
        #1;
        next_cyc();
        div_load = 1'b0;
        #1;
        chk("pre_reset_pend", load_pend, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_sample", sample_tck, 0);
        chk("async_rst_ovs", ovs_cnt, 0);
        chk("async_rst_pend", load_pend, 0);
        next_cyc();
        reset = 1'b0;
        #1;
        do_restart();
        meas(0, n, g);
        chk("post_reset_default_len", n, DEF_DIV);

        for (int r = 0; r < 5; r++) begin
            d = ($urandom_range(4) == 0) ? int'($urandom_range(1)) : int'($urandom_range(12, 2));
            f = int'($urandom_range(FSCALE - 1));
            load_direct(d, f);
            do_restart();
            for (int k = 0; k < 2 * OVS; k++) begin
                meas(1, n, g);
                chk($sformatf("rnd%0d_d%0d_f%0d_len%0d", r, d, f, k), n, model_len(d, f, k) + g);
                chk($sformatf("rnd%0d_ovs%0d", r, k), ovs_cnt, k % OVS);
                chk($sformatf("rnd%0d_mid%0d", r, k), mid_tck, int'(k % OVS == OVS / 2 - 1));
                chk($sformatf("rnd%0d_bit%0d", r, k), bit_tck, int'(k % OVS == OVS - 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
